// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch tag queue: tag/response layouts and the NOP word.
// Struct field widths follow IFQ_XLEN / IFQ_NUM_HARTS; instantiate ifetch_tagq with matching values.
package ifetch_pkg;

  function automatic int hart_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IFQ_XLEN      = 32;
  localparam int IFQ_NUM_HARTS = 2;
  localparam int IFQ_HART_W    = hart_w(IFQ_NUM_HARTS);

  localparam logic [IFQ_XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [IFQ_XLEN-1:0]   pc;
    logic [IFQ_HART_W-1:0] hart;
    logic                  misalign;
    logic                  killed;
  } ifetch_tag_t;

  typedef struct packed {
    ifetch_tag_t         tag;
    logic [IFQ_XLEN-1:0] inst;
  } ifetch_resp_t;

endpackage

// File: rtl/ifetch_killq.sv
// In-order FIFO whose entries carry a hart id and a kill flag; a broadcast kill marks
// every stored entry of the given hart. Head is read straight from the register array.
module ifetch_killq #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int HW    = 1,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_dat,
  input  logic [HW-1:0] i_push_hart,
  input  logic          i_push_killed,
  input  logic          i_pop,
  input  logic          i_kill_vld,
  input  logic [HW-1:0] i_kill_hart,
  output logic [CW-1:0] o_count,
  output logic [DW-1:0] o_head_dat,
  output logic [HW-1:0] o_head_hart,
  output logic          o_head_killed
);

  logic [DW-1:0]    r_dat  [DEPTH];
  logic [HW-1:0]    r_hart [DEPTH];
  logic [DEPTH-1:0] r_killed;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full = (r_cnt == CW'(DEPTH));
  assign w_pop  = i_pop && (r_cnt != '0);
  assign w_push = i_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
      r_killed <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill_vld && (r_hart[i] == i_kill_hart)) r_killed[i] <= 1'b1;
      end
      // The slot being written takes the caller's kill flag, overriding the broadcast.
      if (w_push) begin
        r_killed[r_wr] <= i_push_killed;
        r_wr           <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dat[r_wr]  <= i_push_dat;
      r_hart[r_wr] <= i_push_hart;
    end
  end

  assign o_count       = r_cnt;
  assign o_head_dat    = r_dat[r_rd];
  assign o_head_hart   = r_hart[r_rd];
  assign o_head_killed = r_killed[r_rd];

endmodule

// File: rtl/ifetch_tagq.sv
// Multi-hart fetch front end: tags each BRAM read with pc/hart so returned words stay paired,
// with per-hart flush, credit-limited issue and misaligned-PC reporting.
module ifetch_tagq
  import ifetch_pkg::*;
#(
  parameter int XLEN            = IFQ_XLEN,
  parameter int NUM_HARTS       = IFQ_NUM_HARTS,
  parameter int MAX_OUTSTANDING = 4,
  parameter int MEM_ADDR_W      = 14,
  localparam int HART_W         = hart_w(NUM_HARTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [XLEN-1:0]       req_pc,
  input  logic [HART_W-1:0]     req_hart,
  input  logic                  flush_valid,
  input  logic [HART_W-1:0]     flush_hart,
  output logic                  mem_req,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [XLEN-1:0]       if_pc,
  output logic [XLEN-1:0]       if_inst,
  output logic [HART_W-1:0]     if_hart,
  output logic                  if_misalign
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW:0] LP_MAX = (CW + 1)'(MAX_OUTSTANDING);

  logic [CW-1:0]     w_tq_cnt;
  logic [CW-1:0]     w_rb_cnt;
  logic [CW:0]       w_inflight;
  logic              w_credit;

  logic [XLEN:0]     w_tq_head_dat;
  logic [HART_W-1:0] w_tq_head_hart;
  logic              w_tq_head_killed;
  ifetch_tag_t       w_tq_head;
  logic              w_tq_pop;

  logic [2*XLEN:0]   w_rb_head_dat;
  logic [HART_W-1:0] w_rb_head_hart;
  logic              w_rb_head_killed;
  ifetch_resp_t      w_rb_head;
  logic              w_rb_push;
  logic              w_rb_push_killed;
  logic              w_rb_pop;
  logic              w_rb_present;
  logic              w_flush_hit;

  // Killed entries still hold a credit until they drain, so the response buffer cannot overflow.
  assign w_inflight = {1'b0, w_tq_cnt} + {1'b0, w_rb_cnt};
  assign w_credit   = (w_inflight < LP_MAX);

  assign mem_req   = rst_n && req_valid && w_credit;
  assign mem_addr  = req_pc[MEM_ADDR_W+1:2];
  assign req_ready = mem_req && mem_gnt;

  ifetch_killq #(
    .DEPTH (MAX_OUTSTANDING),
    .DW    (XLEN + 1),
    .HW    (HART_W)
  ) u_tagq (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push        (req_ready),
    .i_push_dat    ({req_pc, |req_pc[1:0]}),
    .i_push_hart   (req_hart),
    .i_push_killed (1'b0),
    .i_pop         (w_tq_pop),
    .i_kill_vld    (flush_valid),
    .i_kill_hart   (flush_hart),
    .o_count       (w_tq_cnt),
    .o_head_dat    (w_tq_head_dat),
    .o_head_hart   (w_tq_head_hart),
    .o_head_killed (w_tq_head_killed)
  );

  assign w_tq_head = {w_tq_head_dat[XLEN:1], w_tq_head_hart, w_tq_head_dat[0], w_tq_head_killed};

  assign w_tq_pop         = mem_rvalid && (w_tq_cnt != '0);
  assign w_rb_push        = w_tq_pop && !w_tq_head.killed;
  assign w_rb_push_killed = flush_valid && (w_tq_head.hart == flush_hart);

  ifetch_killq #(
    .DEPTH (MAX_OUTSTANDING),
    .DW    (2 * XLEN + 1),
    .HW    (HART_W)
  ) u_respq (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push        (w_rb_push),
    .i_push_dat    ({w_tq_head.pc, w_tq_head.misalign, mem_rdata}),
    .i_push_hart   (w_tq_head.hart),
    .i_push_killed (w_rb_push_killed),
    .i_pop         (w_rb_pop),
    .i_kill_vld    (flush_valid),
    .i_kill_hart   (flush_hart),
    .o_count       (w_rb_cnt),
    .o_head_dat    (w_rb_head_dat),
    .o_head_hart   (w_rb_head_hart),
    .o_head_killed (w_rb_head_killed)
  );

  assign w_rb_head = {w_rb_head_dat[2*XLEN:XLEN+1], w_rb_head_hart, w_rb_head_dat[XLEN],
                      w_rb_head_killed, w_rb_head_dat[XLEN-1:0]};

  // A head belonging to the hart being flushed this cycle must not transfer.
  assign w_rb_present = (w_rb_cnt != '0) && !w_rb_head.tag.killed;
  assign w_flush_hit  = flush_valid && (w_rb_head.tag.hart == flush_hart);
  assign if_valid     = w_rb_present && !w_flush_hit;
  assign w_rb_pop     = ((w_rb_cnt != '0) && w_rb_head.tag.killed) || (if_valid && if_ready);

  assign if_pc       = if_valid ? w_rb_head.tag.pc : '0;
  assign if_hart     = if_valid ? w_rb_head.tag.hart : '0;
  assign if_misalign = if_valid && w_rb_head.tag.misalign;
  assign if_inst     = !if_valid ? '0 : (w_rb_head.tag.misalign ? NOP_INST : w_rb_head.inst);

  a_rvalid_has_tag : assert property (@(posedge clk) disable iff (!rst_n)
    (mem_rvalid && $past(rst_n)) |-> (w_tq_cnt != '0));

endmodule

// File: tb/tb_ifetch_tagq.sv
// Directed bench for ifetch_tagq with a 1/2-cycle BRAM model and an output capture queue.
module tb_ifetch_tagq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_pc = '0;
  logic        req_hart = 1'b0;
  logic        flush_valid = 1'b0;
  logic        flush_hart = 1'b0;
  logic        mem_req;
  logic [13:0] mem_addr;
  logic        mem_gnt = 1'b1;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_hart;
  logic        if_misalign;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int lat = 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        hart;
    logic        mis;
    int          cyc;
  } obs_t;
  obs_t obs[$];

  logic [31:0] mem [16384];
  logic        p1_v = 1'b0, p2_v = 1'b0;
  logic [31:0] p1_d = '0, p2_d = '0;

  ifetch_tagq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc), .req_hart(req_hart),
    .flush_valid(flush_valid), .flush_hart(flush_hart),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .if_hart(if_hart), .if_misalign(if_misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    p1_v <= mem_req && mem_gnt;
    p1_d <= mem[mem_addr];
    p2_v <= p1_v;
    p2_d <= p1_d;
  end
  assign mem_rvalid = (lat == 2) ? p2_v : p1_v;
  assign mem_rdata  = (lat == 2) ? p2_d : p1_d;

  always @(negedge clk) begin
    if (if_valid && if_ready) obs.push_back('{pc: if_pc, inst: if_inst, hart: if_hart, mis: if_misalign, cyc: cyc});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic h);
    req_valid = 1'b1;
    req_pc    = pc;
    req_hart  = h;
    #1;
    check("req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget);
    int k = 0;
    while (obs.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("obs_count", obs.size(), n);
  endtask

  function automatic logic [31:0] winst(input int i);
    return 32'h0010_0013 + (i << 20);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int acc;
    logic [31:0] pc;

    for (int i = 0; i < 16384; i++) mem[i] = '0;
    for (int i = 0; i < 64; i++) mem[i] = winst(i);
    mem[64]  = 32'h00A0_0093;
    mem[128] = 32'h0000_0063;

    // Reset with a request pending: nothing may be issued or presented.
    rst_n = 1'b0; req_valid = 1'b1; req_pc = 32'h40;
    tick(); tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_if_inst", if_inst, 0);
    check("rst_if_hart", if_hart, 0);
    check("rst_if_mis", if_misalign, 0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Aligned stream, 1-cycle BRAM.
    if_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 6; i++) issue(32'(4 * i), 1'b0);
    wait_obs(6, 20);
    for (int i = 0; i < obs.size() && i < 6; i++) begin
      check("s1_pc", obs[i].pc, 32'(4 * i));
      check("s1_inst", obs[i].inst, winst(i));
      check("s1_cyc", obs[i].cyc, t0 + 2 + i);
    end
    obs.delete();
    tick(); tick();

    // Interleaved harts.
    for (int i = 0; i < 3; i++) begin
      issue(32'(4 * i), 1'b0);
      issue(32'h200, 1'b1);
    end
    wait_obs(6, 20);
    for (int i = 0; i < obs.size() && i < 6; i++) begin
      check("il_hart", obs[i].hart, i % 2);
      check("il_inst", obs[i].inst, (i % 2) ? 32'h63 : winst(i / 2));
    end
    obs.delete();
    tick(); tick();

    // Backpressure: credits stop issue at MAX_OUTSTANDING.
    if_ready = 1'b0; acc = 0; pc = '0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_pc = pc; req_hart = 1'b0;
      #1;
      if (req_ready) begin
        acc++;
        pc += 4;
      end
      tick();
    end
    req_valid = 1'b1;
    #1;
    check("bp_ready_off", req_ready, 0);
    check("bp_accepted", acc, 4);
    req_valid = 1'b0;
    if_ready = 1'b1;
    wait_obs(4, 20);
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      check("bp_pc", obs[i].pc, 32'(4 * i));
      check("bp_inst", obs[i].inst, winst(i));
    end
    obs.delete();
    tick(); tick();

    // Flush of three buffered hart-0 fetches together with the redirect request.
    if_ready = 1'b0;
    issue(32'h20, 1'b0);
    issue(32'h24, 1'b0);
    issue(32'h28, 1'b0);
    req_valid = 1'b1; req_pc = 32'h100; req_hart = 1'b0;
    flush_valid = 1'b1; flush_hart = 1'b0;
    #1;
    check("fl_req_ready", req_ready, 1);
    check("fl_if_masked", if_valid, 0);
    tick();
    flush_valid = 1'b0; req_valid = 1'b0; if_ready = 1'b1;
    wait_obs(1, 20);
    if (obs.size() > 0) begin
      check("fl_pc", obs[0].pc, 32'h100);
      check("fl_inst", obs[0].inst, 32'h00A0_0093);
    end
    repeat (6) tick();
    check("fl_no_stale", obs.size(), 1);
    obs.delete();

    // Misaligned PC yields a NOP with the flag set.
    issue(32'h6, 1'b1);
    wait_obs(1, 10);
    if (obs.size() > 0) begin
      check("mis_flag", obs[0].mis, 1);
      check("mis_inst", obs[0].inst, 32'h13);
      check("mis_pc", obs[0].pc, 32'h6);
      check("mis_hart", obs[0].hart, 1);
    end
    obs.delete();
    tick(); tick();

    // Two-cycle BRAM stream.
    lat = 2;
    tick();
    t0 = cyc;
    for (int i = 0; i < 4; i++) issue(32'(4 * i), 1'b0);
    wait_obs(4, 20);
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      check("l2_pc", obs[i].pc, 32'(4 * i));
      check("l2_inst", obs[i].inst, winst(i));
      check("l2_mis", obs[i].mis, 0);
      check("l2_cyc", obs[i].cyc, t0 + 3 + i);
    end
    obs.delete();
    tick(); tick(); tick();
    lat = 1;
    tick();

    // Reset while two fetches are outstanding.
    if_ready = 1'b0;
    issue(32'h40, 1'b0);
    issue(32'h44, 1'b0);
    check("mr_pre_valid", if_valid, 1);
    rst_n = 1'b0; req_valid = 1'b1; req_pc = 32'h48;
    tick();
    check("mr_if_valid", if_valid, 0);
    check("mr_if_pc", if_pc, 0);
    check("mr_if_inst", if_inst, 0);
    check("mr_req_ready", req_ready, 0);
    check("mr_mem_req", mem_req, 0);
    tick();
    rst_n = 1'b1; req_valid = 1'b0; if_ready = 1'b1;
    repeat (8) tick();
    check("mr_no_stale", obs.size(), 0);
    check("mr_if_idle", if_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
